// File: rtl/dep_release_unit_pkg.sv
// Shared types for the dependency release unit: per-slot state encoding and
// default slot count / index width.
package dep_release_unit_pkg;

   localparam int BS    = 16;
   localparam int IDX_W = $clog2(BS);

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      WAITING = 2'd1,
      ISSUED  = 2'd2
   } slot_state_t;

endpackage

// File: rtl/dep_release_unit_if.sv
// Bundle of allocation, completion, issue handshake and status signals for the
// dependency release unit. The slave side is the unit itself.
interface dep_release_unit_if
   import dep_release_unit_pkg::*;
#(
   parameter int bs = BS
) ();

   localparam int iw = $clog2(bs);

   logic          alloc_valid;
   logic [iw-1:0] alloc_index;
   logic [bs-1:0] alloc_idt;
   logic          cmpl_valid;
   logic [iw-1:0] cmpl_index;
   logic          issue_valid;
   logic [iw-1:0] issue_index;
   logic          issue_ready;
   logic [iw:0]   occupancy;
   logic          full;
   logic          alloc_err;
   logic          cmpl_err;

   modport master (
      output alloc_valid, alloc_index, alloc_idt,
      output cmpl_valid, cmpl_index,
      output issue_ready,
      input  issue_valid, issue_index,
      input  occupancy, full, alloc_err, cmpl_err
   );

   modport slave (
      input  alloc_valid, alloc_index, alloc_idt,
      input  cmpl_valid, cmpl_index,
      input  issue_ready,
      output issue_valid, issue_index,
      output occupancy, full, alloc_err, cmpl_err
   );

endinterface

// File: rtl/dep_release_unit_prio_enc_lsb.sv
// Lowest-set-bit priority encoder: reports whether any request bit is set and
// the index of the lowest one (0 when none).
module prio_enc_lsb #(
   parameter int width = 16
) (
   input  logic [width-1:0]         req,
   output logic                     valid,
   output logic [$clog2(width)-1:0] index
);

   localparam int iw = $clog2(width);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = width - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            index = iw'(i);
         end
      end
   end

endmodule

// File: rtl/dep_release_unit.sv
// Holds each buffered instruction's dependency row and slot state, and offers
// the lowest-numbered slot whose dependencies have all completed.
module dep_release_unit
   import dep_release_unit_pkg::*;
#(
   parameter int bs = BS
) (
   input  logic               clk,
   input  logic               rst_n,
   dep_release_unit_if.slave  bus
);

   localparam int iw = $clog2(bs);

   slot_state_t   state [bs];
   logic [bs-1:0] dep   [bs];

   logic [bs-1:0] ready;
   logic [bs-1:0] free_eff;
   logic [bs-1:0] cmpl_col;
   logic [bs-1:0] alloc_row [bs];
   logic          cmpl_ok;
   logic          alloc_ok;
   logic          fire;
   logic          enc_valid;
   logic [iw-1:0] enc_index;
   logic [iw:0]   occ;
   logic          alloc_err_q;
   logic          cmpl_err_q;

   assign cmpl_ok = bus.cmpl_valid && (state[bus.cmpl_index] == ISSUED);

   // A slot completing this cycle is treated as already free, both for
   // accepting a new allocation into it and for filtering new dependencies.
   for (genvar g = 0; g < bs; g++) begin : g_slot
      assign cmpl_col[g]  = cmpl_ok && (bus.cmpl_index == iw'(g));
      assign free_eff[g]  = (state[g] == FREE) || cmpl_col[g];
      assign ready[g]     = (state[g] == WAITING) && (dep[g] == '0);
      assign alloc_row[g] = bus.alloc_idt & ~free_eff & ~(bs'(1) << g);
   end

   assign alloc_ok = bus.alloc_valid && free_eff[bus.alloc_index];

   prio_enc_lsb #(
      .width (bs)
   ) u_prio (
      .req   (ready),
      .valid (enc_valid),
      .index (enc_index)
   );

   assign fire = enc_valid && bus.issue_ready;

   assign bus.issue_valid = enc_valid;
   assign bus.issue_index = enc_index;
   assign bus.occupancy   = occ;
   assign bus.full        = (occ == (iw + 1)'(bs));
   assign bus.alloc_err   = alloc_err_q;
   assign bus.cmpl_err    = cmpl_err_q;

   // Slot lifecycle: FREE -> WAITING -> ISSUED -> FREE. An allocation can only
   // coincide with a completion on the same slot, and then it wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < bs; i++) begin
            state[i] <= FREE;
            dep[i]   <= '0;
         end
         occ         <= '0;
         alloc_err_q <= 1'b0;
         cmpl_err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < bs; i++) begin
            if (alloc_ok && (bus.alloc_index == iw'(i))) begin
               state[i] <= WAITING;
               dep[i]   <= alloc_row[i];
            end else begin
               dep[i] <= dep[i] & ~cmpl_col;
               if (fire && (enc_index == iw'(i))) begin
                  state[i] <= ISSUED;
               end else if (cmpl_col[i]) begin
                  state[i] <= FREE;
               end
            end
         end

         case ({alloc_ok, cmpl_ok})
            2'b10:   occ <= occ + (iw + 1)'(1);
            2'b01:   occ <= occ - (iw + 1)'(1);
            default: occ <= occ;
         endcase

         alloc_err_q <= bus.alloc_valid && !alloc_ok;
         cmpl_err_q  <= bus.cmpl_valid && !cmpl_ok;
      end
   end

endmodule

// File: tb/tb_dep_release_unit.sv
// Directed bench for dep_release_unit with bs = 16: allocation, issue,
// completion, dependency chains, error pulses, fill/priority and reset.
module tb_dep_release_unit;

   logic clk;
   logic rst_n;
   int   err_count;
   int   check_count;

   dep_release_unit_if #(.bs(16)) bus ();

   dep_release_unit #(.bs(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, clock them in, then return to idle inputs
   // #1 after the edge so checks see the freshly registered state.
   task automatic applyStimulus(input logic av, input logic [3:0] ai,
                                input logic [15:0] aidt, input logic cv,
                                input logic [3:0] ci, input logic ir);
      bus.alloc_valid = av;
      bus.alloc_index = ai;
      bus.alloc_idt   = aidt;
      bus.cmpl_valid  = cv;
      bus.cmpl_index  = ci;
      bus.issue_ready = ir;
      @(posedge clk);
      #1;
      bus.alloc_valid = 1'b0;
      bus.alloc_index = '0;
      bus.alloc_idt   = '0;
      bus.cmpl_valid  = 1'b0;
      bus.cmpl_index  = '0;
      bus.issue_ready = 1'b0;
   endtask

   initial begin
      err_count   = 0;
      check_count = 0;
      rst_n           = 1'b0;
      bus.alloc_valid = 1'b0;
      bus.alloc_index = '0;
      bus.alloc_idt   = '0;
      bus.cmpl_valid  = 1'b0;
      bus.cmpl_index  = '0;
      bus.issue_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(0, 0, 16'h0000, 0, 0, 0);
      checkOutput("rst_issue_valid", bus.issue_valid, 0);
      checkOutput("rst_issue_index", bus.issue_index, 0);
      checkOutput("rst_occupancy", bus.occupancy, 0);
      checkOutput("rst_full", bus.full, 0);
      checkOutput("rst_alloc_err", bus.alloc_err, 0);
      checkOutput("rst_cmpl_err", bus.cmpl_err, 0);

      // Single independent instruction in slot 3
      applyStimulus(1, 3, 16'h0000, 0, 0, 1);
      checkOutput("s3_valid", bus.issue_valid, 1);
      checkOutput("s3_index", bus.issue_index, 3);
      checkOutput("s3_occ", bus.occupancy, 1);
      applyStimulus(0, 0, 16'h0000, 0, 0, 1);
      checkOutput("s3_issued_valid", bus.issue_valid, 0);
      applyStimulus(0, 0, 16'h0000, 1, 3, 0);
      checkOutput("s3_cmpl_err", bus.cmpl_err, 0);
      checkOutput("s3_cmpl_occ", bus.occupancy, 0);

      // Chain: slot 1 depends on slot 0
      applyStimulus(1, 0, 16'h0000, 0, 0, 0);
      checkOutput("chain_s0_index", bus.issue_index, 0);
      applyStimulus(1, 1, 16'h0001, 0, 0, 1);
      checkOutput("chain_s1_blocked", bus.issue_valid, 0);
      checkOutput("chain_occ", bus.occupancy, 2);
      applyStimulus(0, 0, 16'h0000, 1, 0, 0);
      checkOutput("chain_s1_valid", bus.issue_valid, 1);
      checkOutput("chain_s1_index", bus.issue_index, 1);
      checkOutput("chain_occ_after", bus.occupancy, 1);
      applyStimulus(0, 0, 16'h0000, 0, 0, 1);
      applyStimulus(0, 0, 16'h0000, 1, 1, 0);
      checkOutput("chain_drain_occ", bus.occupancy, 0);

      // Completion of slot 2 in the same cycle as a dependent allocation
      applyStimulus(1, 2, 16'h0000, 0, 0, 0);
      applyStimulus(0, 0, 16'h0000, 0, 0, 1);
      checkOutput("same_s2_issued", bus.issue_valid, 0);
      applyStimulus(1, 5, 16'h0004, 1, 2, 0);
      checkOutput("same_s5_valid", bus.issue_valid, 1);
      checkOutput("same_s5_index", bus.issue_index, 5);
      checkOutput("same_occ", bus.occupancy, 1);

      // Error pulses
      applyStimulus(1, 5, 16'hFFFF, 0, 0, 0);
      checkOutput("aerr_pulse", bus.alloc_err, 1);
      checkOutput("aerr_occ", bus.occupancy, 1);
      checkOutput("aerr_s5_index", bus.issue_index, 5);
      applyStimulus(0, 0, 16'h0000, 1, 7, 0);
      checkOutput("aerr_clear", bus.alloc_err, 0);
      checkOutput("cerr_free_pulse", bus.cmpl_err, 1);
      checkOutput("cerr_free_occ", bus.occupancy, 1);
      applyStimulus(0, 0, 16'h0000, 1, 5, 0);
      checkOutput("cerr_wait_pulse", bus.cmpl_err, 1);
      checkOutput("cerr_wait_occ", bus.occupancy, 1);
      checkOutput("cerr_wait_s5", bus.issue_index, 5);
      applyStimulus(0, 0, 16'h0000, 0, 0, 0);
      checkOutput("cerr_clear", bus.cmpl_err, 0);

      // Slot 6 depends on WAITING slot 5 (kept) and FREE slot 7 (dropped)
      applyStimulus(1, 6, 16'h00A0, 0, 0, 0);
      checkOutput("filt_offer_s5", bus.issue_index, 5);
      applyStimulus(0, 0, 16'h0000, 0, 0, 1);
      checkOutput("filt_s6_blocked", bus.issue_valid, 0);
      applyStimulus(0, 0, 16'h0000, 1, 5, 0);
      checkOutput("filt_s6_valid", bus.issue_valid, 1);
      checkOutput("filt_s6_index", bus.issue_index, 6);
      applyStimulus(0, 0, 16'h0000, 0, 0, 1);
      applyStimulus(0, 0, 16'h0000, 1, 6, 0);
      checkOutput("filt_drain_occ", bus.occupancy, 0);

      // Fill all slots, then issue in priority order with no bubbles
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1, 4'(k), 16'h0000, 0, 0, 0);
         if (k == 14) checkOutput("fill_not_full", bus.full, 0);
      end
      checkOutput("fill_full", bus.full, 1);
      checkOutput("fill_occ", bus.occupancy, 16);
      for (int k = 0; k < 16; k++) begin
         checkOutput("order_valid", bus.issue_valid, 1);
         checkOutput("order_index", bus.issue_index, k);
         applyStimulus(0, 0, 16'h0000, 0, 0, 1);
      end
      checkOutput("order_done", bus.issue_valid, 0);
      checkOutput("order_occ", bus.occupancy, 16);
      applyStimulus(1, 4, 16'h0000, 1, 4, 0);
      checkOutput("recycle_aerr", bus.alloc_err, 0);
      checkOutput("recycle_cerr", bus.cmpl_err, 0);
      checkOutput("recycle_occ", bus.occupancy, 16);
      checkOutput("recycle_index", bus.issue_index, 4);
      applyStimulus(1, 9, 16'h0000, 0, 0, 0);
      checkOutput("full_aerr", bus.alloc_err, 1);
      checkOutput("full_occ", bus.occupancy, 16);

      // Asynchronous reset between edges drops everything at once
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_occ", bus.occupancy, 0);
      checkOutput("arst_full", bus.full, 0);
      checkOutput("arst_issue_valid", bus.issue_valid, 0);
      checkOutput("arst_alloc_err", bus.alloc_err, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule
